// File: rtl/stump_mem_responder.sv
// Word-addressed memory responder for the STUMP processor bus.
// It accepts one level-held read or write request in IDLE, waits WAIT
// cycles, then answers with a single-cycle mem_ready strobe. Addresses
// outside the implemented 2^AW words, or a request that asserts both read
// and write, complete with mem_err set and never modify memory.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no transaction open; a request is captured on the next edge
// S_WAITING | counting down the inserted wait cycles
// S_RESP    | mem_ready high for this single cycle; write lands at its end
module stump_mem_responder #(
  parameter int WAIT = 1,
  parameter int AW   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  input  logic        mem_ren,
  input  logic        mem_wen,
  output logic [15:0] data_in,
  output logic        mem_ready,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAITING = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;
  logic [15:0]     data_q, data_d;
  logic            mem_we;

  // No reset on the array: contents survive rst_n by design.
  logic [15:0]     mem_q [2**AW];

  logic            req;
  logic            out_of_range;

  assign req          = mem_ren | mem_wen;
  assign out_of_range = (address >> AW) != 16'h0000;

  // State register plus captured transaction fields and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: capture in IDLE, count down in WAITING, always leave RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = address[AW-1:0];
          wdata_d = data_out;
          rd_d    = mem_ren;
          wr_d    = mem_wen;
          err_d   = out_of_range | (mem_ren & mem_wen);
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_CNT != 4'd0) ? S_WAITING : S_RESP;
        end
      end
      S_WAITING: begin
        cnt_d = cnt_q - 4'd1;
        // <= also catches a zero count so the FSM can never stall here.
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Read data is loaded on the edge entering RESP so it is valid with
  // mem_ready; the _d fields cover the WAIT=0 case where capture and
  // RESP entry share one edge. A read-write collision also clears it.
  always_comb begin
    data_d = data_q;
    if (state_d == S_RESP && state_q != S_RESP && rd_d) begin
      data_d = err_d ? 16'h0000 : mem_q[addr_d];
    end
  end

  // Outputs and the memory write enable, decoded from the current state.
  always_comb begin
    mem_ready = (state_q == S_RESP);
    mem_err   = (state_q == S_RESP) & err_q;
    mem_we    = (state_q == S_RESP) & wr_q & ~err_q;
    data_in   = data_q;
  end

  // Memory write on the edge that closes the RESP cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_stump_mem_responder.sv
// Bench for stump_mem_responder: three instances (WAIT = 0, 1, 3) driven
// by directed transactions; expected responses go into a scoreboard queue
// and per-instance monitors pop and compare whenever mem_ready is high.
module tb_stump_mem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n [N];
  logic [15:0] addr  [N];
  logic [15:0] wdat  [N];
  logic        ren   [N];
  logic        wen   [N];
  logic [15:0] rdat  [N];
  logic        rdy   [N];
  logic        err   [N];

  always #5 clk = ~clk;

  stump_mem_responder #(.WAIT(0), .AW(8)) u_w0 (
    .clk(clk), .rst_n(rst_n[0]), .address(addr[0]), .data_out(wdat[0]),
    .mem_ren(ren[0]), .mem_wen(wen[0]), .data_in(rdat[0]),
    .mem_ready(rdy[0]), .mem_err(err[0]));

  stump_mem_responder #(.WAIT(1), .AW(8)) u_w1 (
    .clk(clk), .rst_n(rst_n[1]), .address(addr[1]), .data_out(wdat[1]),
    .mem_ren(ren[1]), .mem_wen(wen[1]), .data_in(rdat[1]),
    .mem_ready(rdy[1]), .mem_err(err[1]));

  stump_mem_responder #(.WAIT(3), .AW(8)) u_w3 (
    .clk(clk), .rst_n(rst_n[2]), .address(addr[2]), .data_out(wdat[2]),
    .mem_ren(ren[2]), .mem_wen(wen[2]), .data_in(rdat[2]),
    .mem_ready(rdy[2]), .mem_err(err[2]));

  typedef struct {
    int          dut;
    logic        exp_err;
    bit          chk_data;
    logic [15:0] exp_data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic int wait_of(int d);
    case (d)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per mem_ready pulse; mem_err must be low otherwise.
  for (genvar g = 0; g < N; g++) begin : g_mon
    logic prev_rdy = 1'b0;
    exp_t e;
    always @(negedge clk) begin
      if (rst_n[g] !== 1'b1) begin
        prev_rdy <= 1'b0;
      end else begin
        if (rdy[g] === 1'b1) begin
          check($sformatf("dut%0d no back-to-back ready", g), 32'(prev_rdy), 32'd0);
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d unexpected mem_ready: got pulse expected none", g);
          end else begin
            e = sb.pop_front();
            check($sformatf("%s dut id", e.name), 32'(g), 32'(e.dut));
            check($sformatf("%s mem_err", e.name), 32'(err[g]), 32'(e.exp_err));
            if (e.chk_data)
              check($sformatf("%s data_in", e.name), 32'(rdat[g]), 32'(e.exp_data));
          end
        end else begin
          check($sformatf("dut%0d mem_err idle", g), 32'(err[g]), 32'd0);
        end
        prev_rdy <= rdy[g];
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic txn(int d, bit r, bit w, logic [15:0] a, logic [15:0] wd,
                     bit e_err, bit chk, logic [15:0] e_data,
                     bit alt, logic [15:0] alt_a, logic [15:0] alt_d, string name);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    sb.push_back('{d, e_err, chk, e_data, name});
    addr[d] = a;
    wdat[d] = wd;
    ren[d]  = r;
    wen[d]  = w;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (alt && cyc == 1) begin
        addr[d] = alt_a;
        wdat[d] = alt_d;
      end
      if (rdy[d] === 1'b1) seen = 1'b1;
    end
    ren[d] = 1'b0;
    wen[d] = 1'b0;
    check($sformatf("%s latency", name), 32'(cyc), 32'(wait_of(d) + 1));
    @(negedge clk);
  endtask

  task automatic wr(int d, logic [15:0] a, logic [15:0] v, bit e_err, string name);
    txn(d, 1'b0, 1'b1, a, v, e_err, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, name);
  endtask

  task automatic rd(int d, logic [15:0] a, bit e_err, logic [15:0] e_data, string name);
    txn(d, 1'b1, 1'b0, a, 16'h0, e_err, 1'b1, e_data, 1'b0, 16'h0, 16'h0, name);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0;
      addr[i]  = 16'h0;
      wdat[i]  = 16'h0;
      ren[i]   = 1'b0;
      wen[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset dut%0d data_in", i), 32'(rdat[i]), 32'h0);
      check($sformatf("reset dut%0d mem_ready", i), 32'(rdy[i]), 32'h0);
      check($sformatf("reset dut%0d mem_err", i), 32'(err[i]), 32'h0);
    end
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

    // WAIT=1: request presented right at reset release is accepted on the next edge.
    wr(1, 16'h0012, 16'hBEEF, 1'b0, "w1 wr 0012");
    rd(1, 16'h0012, 1'b0, 16'hBEEF, "w1 rd 0012");
    txn(1, 1'b0, 1'b1, 16'h0012, 16'hCAFE, 1'b0, 1'b1, 16'hBEEF,
        1'b0, 16'h0, 16'h0, "w1 wr keeps data_in");
    rd(1, 16'h0012, 1'b0, 16'hCAFE, "w1 rd 0012 new");
    wr(1, 16'h0000, 16'h1111, 1'b0, "w1 wr 0000");
    rd(1, 16'h0100, 1'b1, 16'h0000, "w1 rd oor 0100");
    txn(1, 1'b0, 1'b1, 16'h0100, 16'h1234, 1'b1, 1'b1, 16'h0000,
        1'b0, 16'h0, 16'h0, "w1 wr oor 0100");
    rd(1, 16'h0000, 1'b0, 16'h1111, "w1 rd 0000 intact");
    wr(1, 16'h0003, 16'h2222, 1'b0, "w1 wr 0003");
    txn(1, 1'b1, 1'b1, 16'h0003, 16'h5555, 1'b1, 1'b1, 16'h0000,
        1'b0, 16'h0, 16'h0, "w1 both 0003");
    rd(1, 16'h0003, 1'b0, 16'h2222, "w1 rd 0003 intact");
    wr(1, 16'h00FF, 16'hABCD, 1'b0, "w1 wr 00ff");
    rd(1, 16'h00FF, 1'b0, 16'hABCD, "w1 rd 00ff");
    rd(1, 16'hFFFF, 1'b1, 16'h0000, "w1 rd oor ffff");

    // WAIT=0: held read gives a pulse every second cycle.
    wr(0, 16'h0005, 16'h0505, 1'b0, "w0 wr 0005");
    for (int k = 0; k < 3; k++) sb.push_back('{0, 1'b0, 1'b1, 16'h0505, "w0 held rd"});
    addr[0] = 16'h0005;
    ren[0]  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("w0 held pattern cyc%0d", k), 32'(rdy[0]), 32'((k % 2) == 0));
    end
    ren[0] = 1'b0;
    @(negedge clk);

    // WAIT=3: inputs changed after capture must not redirect the write.
    wr(2, 16'h0007, 16'h7777, 1'b0, "w3 wr 0007");
    txn(2, 1'b0, 1'b1, 16'h0004, 16'h4444, 1'b0, 1'b0, 16'h0,
        1'b1, 16'h0007, 16'h9999, "w3 wr 0004 addr moved");
    rd(2, 16'h0004, 1'b0, 16'h4444, "w3 rd 0004");
    rd(2, 16'h0007, 1'b0, 16'h7777, "w3 rd 0007");

    // WAIT=3: reset in WAITING aborts the write and clears data_in.
    wr(2, 16'h0010, 16'h5A5A, 1'b0, "w3 wr 0010");
    rd(2, 16'h0010, 1'b0, 16'h5A5A, "w3 rd 0010");
    addr[2] = 16'h0010;
    wdat[2] = 16'hFFFF;
    wen[2]  = 1'b1;
    @(negedge clk);
    rst_n[2] = 1'b0;
    wen[2]   = 1'b0;
    #1;
    check("w3 abort data_in", 32'(rdat[2]), 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("w3 abort no ready cyc%0d", k), 32'(rdy[2]), 32'h0);
    end
    rst_n[2] = 1'b1;
    @(negedge clk);
    check("w3 post reset data_in", 32'(rdat[2]), 32'h0);
    rd(2, 16'h0010, 1'b0, 16'h5A5A, "w3 rd 0010 after abort");

    repeat (4) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
